ipa_cfg_scheduler: RTL and testbench

//  Queues kernel-configuration requests (config IDs) from the host side and launches them one at a time on the

---
 rtl/ipa_cfg_scheduler.sv | 143 ++++++++++++++
 tb/tb_ipa_cfg_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipa_cfg_scheduler.sv
// ipa_cfg_scheduler
// Queues kernel-configuration requests (config IDs) from the host and launches
// them one at a time on the context-loading DMA. Only one configuration is in
// flight at any time, which serialises access to the global context memory.
//
// Ports
//   Clk, Reset     rising-edge clock, synchronous active-high reset
//   req_valid_i    request valid; accepted when req_ready_o is high
//   req_id_i       config ID of the request
//   req_ready_o    queue has room (based on registered count only)
//   fetch_en_o     single-cycle context-fetch pulse to the DMA
//   fetch_id_o     config ID qualified by fetch_en_o (0 otherwise)
//   exec_en_i      DMA load-complete pulse (observed only while loading)
//   exec_comp_i    execution-complete pulse (observed only while running)
//   done_valid_o   completion record valid, held until done_ready_i
//   done_id_o      ID of the completed request
//   done_err_o     1 when the load was aborted by the watchdog
//   done_ready_i   requester consumes the completion record
//   pending_o      number of queued, not yet launched requests
//   busy_o         scheduler active or requests pending
module ipa_cfg_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int ID_WIDTH     = 5,
    parameter int LOAD_TIMEOUT = 4096,
    parameter int TO_WIDTH     = 16
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            req_valid_i,
    input  logic [ID_WIDTH-1:0]             req_id_i,
    output logic                            req_ready_o,
    output logic                            fetch_en_o,
    output logic [ID_WIDTH-1:0]             fetch_id_o,
    input  logic                            exec_en_i,
    input  logic                            exec_comp_i,
    output logic                            done_valid_o,
    output logic [ID_WIDTH-1:0]             done_id_o,
    output logic                            done_err_o,
    input  logic                            done_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     pending_o,
    output logic                            busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(LOAD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_LOAD,
        ST_RUN,
        ST_REPORT
    } state_t;

    state_t                 state_reg, state_next;
    logic [ID_WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic [ID_WIDTH-1:0]    head_reg;
    logic [ID_WIDTH-1:0]    cur_id_reg;
    logic                   err_reg;
    logic [TO_WIDTH-1:0]    wd_cnt_reg;
    logic                   push, pop, timeout;

    assign req_ready_o = (count_reg < DEPTH_C);
    assign push        = req_valid_i & req_ready_o;
    assign pop         = (state_reg == ST_LAUNCH);
    assign timeout     = (wd_cnt_reg == WD_LAST);

    // Queue storage has no reset; only slots between the pointers are ever read.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= req_id_i;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (count_reg != '0) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_LOAD;
            // A load-complete pulse wins over a watchdog expiry in the same cycle.
            ST_LOAD: begin
                if (exec_en_i)    state_next = ST_RUN;
                else if (timeout) state_next = ST_REPORT;
            end
            ST_RUN:    if (exec_comp_i)  state_next = ST_REPORT;
            ST_REPORT: if (done_ready_i) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= ST_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            cur_id_reg <= '0;
            err_reg    <= 1'b0;
            wd_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Registered read of the queue head. The head slot is written at
            // least one edge before IDLE moves to LAUNCH, and rd_ptr only moves
            // on leaving LAUNCH, so head_reg is valid throughout LAUNCH.
            head_reg  <= mem[rd_ptr_reg];

            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase

            if (state_reg == ST_LAUNCH) begin
                cur_id_reg <= head_reg;
                wd_cnt_reg <= '0;
            end else if (state_reg == ST_LOAD) begin
                wd_cnt_reg <= wd_cnt_reg + TO_WIDTH'(1);
            end

            if (state_reg == ST_LOAD && !exec_en_i && timeout) begin
                err_reg <= 1'b1;
            end else if (state_reg == ST_RUN && exec_comp_i) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign fetch_en_o   = (state_reg == ST_LAUNCH);
    assign fetch_id_o   = fetch_en_o ? head_reg : '0;
    assign done_valid_o = (state_reg == ST_REPORT);
    assign done_id_o    = done_valid_o ? cur_id_reg : '0;
    assign done_err_o   = done_valid_o & err_reg;
    assign pending_o    = count_reg;
    assign busy_o       = (state_reg != ST_IDLE) | (count_reg != '0);

endmodule

// File: tb/tb_ipa_cfg_scheduler.sv
module tb_ipa_cfg_scheduler;

    localparam int LTO   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [4:0] req_id = '0;
    logic       req_ready;
    logic       fetch_en;
    logic [4:0] fetch_id;
    logic       exec_en = 1'b0;
    logic       exec_comp = 1'b0;
    logic       done_valid;
    logic [4:0] done_id;
    logic       done_err;
    logic       done_ready = 1'b0;
    logic [2:0] pending;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    ipa_cfg_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .ID_WIDTH    (5),
        .LOAD_TIMEOUT(LTO),
        .TO_WIDTH    (16)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .req_valid_i (req_valid),
        .req_id_i    (req_id),
        .req_ready_o (req_ready),
        .fetch_en_o  (fetch_en),
        .fetch_id_o  (fetch_id),
        .exec_en_i   (exec_en),
        .exec_comp_i (exec_comp),
        .done_valid_o(done_valid),
        .done_id_o   (done_id),
        .done_err_o  (done_err),
        .done_ready_i(done_ready),
        .pending_o   (pending),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Job-level view: a list of waiting IDs plus the one job in flight and
    // how far it has progressed (0 none, 1 fetch issued, 2 loading,
    // 3 executing, 4 result offered).
    int mq[$];
    int job_stage = 0;
    int job_id    = 0;
    bit job_err   = 0;
    int job_age   = 0;
    int got_ids[$];
    int got_err[$];

    function automatic logic [17:0] pk(bit r, bit f, logic [4:0] fid, bit dv,
                                       logic [4:0] did, bit de, logic [2:0] p, bit b);
        return {r, f, fid, dv, did, de, p, b};
    endfunction

    function automatic logic [17:0] get_outs();
        return {req_ready, fetch_en, fetch_id, done_valid, done_id, done_err, pending, busy};
    endfunction

    function automatic logic [17:0] model_outs();
        logic [4:0] fid;
        logic [4:0] did;
        fid = (job_stage == 1) ? 5'(mq[0]) : 5'd0;
        did = (job_stage == 4) ? 5'(job_id) : 5'd0;
        return pk(mq.size() < DEPTH, job_stage == 1, fid, job_stage == 4, did,
                  (job_stage == 4) && job_err, 3'(mq.size()),
                  (job_stage != 0) || (mq.size() != 0));
    endfunction

    task automatic model_step(input bit rv, input logic [4:0] rid, input bit ee,
                              input bit ec, input bit dr);
        bit accept;
        accept = rv && (mq.size() < DEPTH);
        case (job_stage)
            0: if (mq.size() != 0) job_stage = 1;
            1: begin job_id = mq.pop_front(); job_age = 0; job_stage = 2; end
            2: begin
                if (ee) job_stage = 3;
                else if (job_age == LTO - 1) begin job_stage = 4; job_err = 1; end
                else job_age++;
            end
            3: if (ec) begin job_stage = 4; job_err = 0; end
            4: if (dr) job_stage = 0;
            default: job_stage = 0;
        endcase
        if (accept) mq.push_back(int'(rid));
    endtask

    task automatic model_reset();
        mq.delete();
        job_stage = 0;
        job_id    = 0;
        job_err   = 0;
        job_age   = 0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit rv, input logic [4:0] rid, input bit ee,
                       input bit ec, input bit dr);
        req_valid  = rv;
        req_id     = rid;
        exec_en    = ee;
        exec_comp  = ec;
        done_ready = dr;
        if (done_valid && dr) begin
            got_ids.push_back(int'(done_id));
            got_err.push_back(int'(done_err));
            $display("done  id=%0d err=%0d  t=%0t", done_id, done_err, $time);
        end
        model_step(rv, rid, ee, ec, dr);
        @(posedge clk);
        #1;
        check("cycle_outputs", get_outs(), model_outs());
        req_valid  = 1'b0;
        exec_en    = 1'b0;
        exec_comp  = 1'b0;
        done_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        exec_en    = 1'b0;
        exec_comp  = 1'b0;
        done_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state", get_outs(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Drive every completion input until the scheduler is empty.
    task automatic drain();
        int n = 0;
        while (busy && n < 200) begin
            cyc(0, 0, 1, 1, 1);
            n++;
        end
        check("drain_idle", 18'(busy), 18'(0));
    endtask

    typedef struct {
        bit          rv;
        logic [4:0]  rid;
        bit          ee;
        bit          ec;
        bit          dr;
        logic [17:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit rv, logic [4:0] rid, bit ee, bit ec, bit dr, logic [17:0] exp);
        vec_t v;
        v.rv = rv; v.rid = rid; v.ee = ee; v.ec = ec; v.dr = dr; v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        int exp_ids[5];
        logic [4:0] held_id;

        // single request: accept, fetch two cycles later, load, run, report
        add(1, 5, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1, 1));
        add(0, 0, 0, 0, 0, pk(1, 1, 5, 0, 0, 0, 1, 1));
        add(0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 1));
        add(0, 0, 1, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 1));
        add(0, 0, 0, 1, 0, pk(1, 0, 0, 1, 5, 0, 0, 1));
        add(0, 0, 0, 0, 0, pk(1, 0, 0, 1, 5, 0, 0, 1));
        add(0, 0, 0, 0, 1, pk(1, 0, 0, 0, 0, 0, 0, 0));
        // stray pulses while idle
        add(0, 0, 1, 1, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        // push while launching with one queued: count stays 1, order kept
        add(1, 7, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1, 1));
        add(0, 0, 0, 0, 0, pk(1, 1, 7, 0, 0, 0, 1, 1));
        add(1, 9, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1, 1));
        add(0, 0, 1, 0, 0, pk(1, 0, 0, 0, 0, 0, 1, 1));
        add(0, 0, 0, 1, 0, pk(1, 0, 0, 1, 7, 0, 1, 1));
        add(0, 0, 0, 0, 1, pk(1, 0, 0, 0, 0, 0, 1, 1));
        add(0, 0, 0, 0, 0, pk(1, 1, 9, 0, 0, 0, 1, 1));
        add(0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 1));
        add(0, 0, 1, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 1));
        add(0, 0, 0, 1, 0, pk(1, 0, 0, 1, 9, 0, 0, 1));
        add(0, 0, 0, 0, 1, pk(1, 0, 0, 0, 0, 0, 0, 0));

        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rv, tbl[i].rid, tbl[i].ee, tbl[i].ec, tbl[i].dr);
            check($sformatf("table_%0d", i), get_outs(), tbl[i].exp);
        end

        // queue full: launch 10, then push 1..5 while it runs
        got_ids.delete();
        cyc(1, 10, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(1, 5'(i), 0, 0, 0);
        check("full_pending", 18'(pending), 18'(4));
        check("full_ready", 18'(req_ready), 18'(0));
        drain();
        exp_ids = '{10, 1, 2, 3, 4};
        check("full_done_count", 18'(got_ids.size()), 18'(5));
        for (int i = 0; i < 5 && i < got_ids.size(); i++)
            check($sformatf("full_order_%0d", i), 18'(got_ids[i]), 18'(exp_ids[i]));

        // watchdog: never acknowledge the load
        cyc(1, 12, 0, 0, 0);
        n = 0;
        while (!fetch_en && n < 10) begin cyc(0, 0, 0, 0, 0); n++; end
        check("wd_fetch_seen", 18'(fetch_en), 18'(1));
        n = 0;
        do begin cyc(0, 0, 0, 0, 0); n++; end while (!done_valid && n < 50);
        check("wd_edges_in_load", 18'(n - 1), 18'(LTO));
        check("wd_err", 18'(done_err), 18'(1));
        check("wd_id", 18'(done_id), 18'(12));
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
        check("wd_still_err", 18'(done_err), 18'(1));
        cyc(0, 0, 0, 0, 1);
        check("wd_released", 18'(busy), 18'(0));

        // backpressure on the completion record with another request queued
        cyc(1, 3, 0, 0, 0);
        cyc(1, 4, 0, 0, 0);
        n = 0;
        while (!done_valid && n < 20) begin cyc(0, 0, 1, 1, 0); n++; end
        check("bp_report", 18'(done_valid), 18'(1));
        held_id = done_id;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 1, 0);
            check("bp_hold", {done_valid, done_id, fetch_en}, {1'b1, held_id, 1'b0});
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("bp_next_launch", {fetch_en, fetch_id}, {1'b1, 5'd4});
        drain();

        // reset while running with two pending
        cyc(1, 20, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 21, 0, 0, 0);
        cyc(1, 22, 0, 0, 0);
        check("rst_pending_before", 18'(pending), 18'(2));
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 2) == 0, 5'($urandom), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
